// File: rtl/log_readout_if.sv
// Bundle of command, logging-memory and byte-stream signals between the
// readout controller (master side) and its environment (slave side).
interface log_readout_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic                  i_cmd_valid;
    logic [1:0]            i_cmd;
    logic                  i_mem_full;
    logic [DATA_WIDTH-1:0] i_data_log;
    logic                  o_run_log;
    logic                  o_read_log;
    logic [ADDR_WIDTH-1:0] o_addr_log;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_timeout;

    modport master (
        input  i_cmd_valid, i_cmd, i_mem_full, i_data_log, i_tx_ready,
        output o_run_log, o_read_log, o_addr_log, o_tx_data, o_tx_valid,
               o_busy, o_done, o_timeout
    );

    modport slave (
        output i_cmd_valid, i_cmd, i_mem_full, i_data_log, i_tx_ready,
        input  o_run_log, o_read_log, o_addr_log, o_tx_data, o_tx_valid,
               o_busy, o_done, o_timeout
    );
endinterface

// File: rtl/log_readout_ctrl.sv
// Logging-memory readout sequencer: arms a capture run, waits for the
// memory-full flag, then walks every address and serialises each read word
// MSB-first onto a valid/ready byte stream.
module log_readout_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1,
    parameter int TIMEOUT_W  = 24
) (
    input  logic          clk,
    input  logic          i_rst,
    log_readout_if.master bus
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BI_W   = $clog2(NBYTES + 1);
    localparam int CNT_W  = $clog2(RD_LAT + 2) + 1;

    localparam logic [1:0] CMD_CAPTURE = 2'd1;
    localparam logic [1:0] CMD_DUMP    = 2'd2;
    localparam logic [1:0] CMD_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_FULL,
        S_READY,
        S_REQ,
        S_SETTLE,
        S_FETCH,
        S_SEND
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BI_W-1:0]       byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0]  wd_q, wd_d, wd_inc;
    logic                  full_seen_q, full_seen_d;
    logic                  timeout_q, timeout_d;
    logic                  run_log_q, run_log_d;
    logic                  read_log_q, read_log_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  cmd_ok;
    logic                  accept;

    // Commands are dropped while any one-cycle pulse output is high.
    assign cmd_ok = bus.i_cmd_valid && !(run_log_q || read_log_q || done_q);
    assign accept = tx_valid_q && bus.i_tx_ready;
    assign wd_inc = wd_q + TIMEOUT_W'(1);

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        full_seen_d = full_seen_q;
        timeout_d   = timeout_q;
        done_d      = 1'b0;

        if (cmd_ok && bus.i_cmd == CMD_ABORT) begin
            // ABORT beats everything, including a last-byte acceptance.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_ok && bus.i_cmd == CMD_CAPTURE) begin
                        state_d = S_ARM;
                    end else if (cmd_ok && bus.i_cmd == CMD_DUMP && full_seen_q) begin
                        state_d = S_REQ;
                    end
                end
                S_ARM: begin
                    timeout_d   = 1'b0;
                    full_seen_d = 1'b0;
                    wd_d        = '0;
                    state_d     = S_WAIT_FULL;
                end
                S_WAIT_FULL: begin
                    wd_d = wd_inc;
                    if (bus.i_mem_full) begin
                        full_seen_d = 1'b1;
                        state_d     = S_READY;
                    end else if (&wd_inc) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                S_READY: begin
                    if (cmd_ok && bus.i_cmd == CMD_DUMP) begin
                        state_d = S_REQ;
                    end else if (cmd_ok && bus.i_cmd == CMD_CAPTURE) begin
                        state_d = S_ARM;
                    end
                end
                S_REQ: begin
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    // Two cycles for the memory to switch into its read state.
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_FETCH: begin
                    // Address is held RD_LAT cycles, then the word is captured.
                    if (cnt_q == CNT_W'(RD_LAT)) begin
                        shift_d    = bus.i_data_log;
                        byte_idx_d = '0;
                        state_d    = S_SEND;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_SEND: begin
                    if (accept) begin
                        shift_d    = shift_q << 8;
                        byte_idx_d = byte_idx_q + BI_W'(1);
                        if (byte_idx_q == BI_W'(NBYTES - 1)) begin
                            if (&addr_q) begin
                                done_d  = 1'b1;
                                state_d = S_READY;
                            end else begin
                                addr_d  = addr_q + ADDR_WIDTH'(1);
                                cnt_d   = '0;
                                state_d = S_FETCH;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered from the state being entered.
        run_log_d  = (state_d == S_ARM);
        read_log_d = (state_d == S_REQ);
        busy_d     = (state_d != S_IDLE);
        tx_valid_d = (state_d == S_SEND);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            full_seen_q <= 1'b0;
            timeout_q   <= 1'b0;
            run_log_q   <= 1'b0;
            read_log_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            full_seen_q <= full_seen_d;
            timeout_q   <= timeout_d;
            run_log_q   <= run_log_d;
            read_log_q  <= read_log_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign bus.o_run_log  = run_log_q;
    assign bus.o_read_log = read_log_q;
    assign bus.o_addr_log = addr_q;
    assign bus.o_tx_data  = shift_q[DATA_WIDTH-1 -: 8];
    assign bus.o_tx_valid = tx_valid_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_timeout  = timeout_q;
endmodule

// File: tb/tb_log_readout_ctrl.sv
// Scoreboard bench for log_readout_ctrl with an 8-word logging memory model.
module tb_log_readout_ctrl;
    localparam int AW = 3;
    localparam int DW = 32;

    localparam logic [1:0] C_CAPTURE = 2'd1;
    localparam logic [1:0] C_DUMP    = 2'd2;
    localparam logic [1:0] C_ABORT   = 2'd3;

    logic clk;
    logic i_rst;

    log_readout_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    log_readout_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RD_LAT    (1),
        .TIMEOUT_W (4)
    ) dut (
        .clk  (clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int run_cnt  = 0;
    int read_cnt = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    bit   bp_en     = 1'b0;
    bit   rdy_fixed = 1'b1;
    bit   hold_v    = 1'b0;
    logic [7:0]    hold_data;
    logic [AW-1:0] hold_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory word for an address: {addr, ~addr}, each 16 bits.
    function automatic logic [7:0] exp_byte(input int a, input int b);
        logic [15:0] hi;
        logic [31:0] w;
        hi = 16'(a);
        w  = {hi, ~hi};
        return w[31-8*b -: 8];
    endfunction

    task automatic push_word(input int a, input int nbytes);
        for (int b = 0; b < nbytes; b++) exp_q.push_back(exp_byte(a, b));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] c);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd       = c;
        step();
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd       = 2'd0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_run"},     bus.o_run_log,  0);
        chk({tag, "_read"},    bus.o_read_log, 0);
        chk({tag, "_addr"},    bus.o_addr_log, 0);
        chk({tag, "_txdata"},  bus.o_tx_data,  0);
        chk({tag, "_txvalid"}, bus.o_tx_valid, 0);
        chk({tag, "_busy"},    bus.o_busy,     0);
        chk({tag, "_done"},    bus.o_done,     0);
        chk({tag, "_timeout"}, bus.o_timeout,  0);
    endtask

    // Issue DUMP with the full expected stream already queued; check
    // pulse, address start, first-byte latency and completion.
    task automatic run_dump(input string tag, input int bound);
        int n;
        int d0;
        d0 = done_cnt;
        cmd(C_DUMP);
        chk({tag, "_read_pulse"}, bus.o_read_log, 1);
        step();
        chk({tag, "_addr0"}, bus.o_addr_log, 0);
        n = 1;
        while (!bus.o_tx_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_first_valid_lat"}, n, 5);
        n = 0;
        while (done_cnt == d0 && n < bound) begin
            step();
            n++;
        end
        step();
        step();
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Logging memory model, one cycle read latency.
    initial begin
        bus.i_data_log = '0;
        forever begin
            @(posedge clk);
            bus.i_data_log <= {16'(bus.o_addr_log), ~16'(bus.o_addr_log)};
        end
    end

    // Stream sink ready: fixed or ~30% random.
    initial begin
        bus.i_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) bus.i_tx_ready = ($urandom_range(0, 9) < 3);
            else       bus.i_tx_ready = rdy_fixed;
        end
    end

    // Monitor: pulse counters, stream scoreboard, stall stability.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus.o_run_log)  run_cnt++;
            if (bus.o_read_log) read_cnt++;
            if (bus.o_done) begin
                done_cnt++;
                chk("done_after_last_byte", exp_q.size(), 0);
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", bus.o_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", bus.o_tx_data, e);
                end
            end
            if (hold_v && bus.o_tx_valid) begin
                chk("stall_data_stable", bus.o_tx_data, hold_data);
                chk("stall_addr_stable", bus.o_addr_log, hold_addr);
            end
            hold_v    = bus.o_tx_valid && !bus.i_tx_ready;
            hold_data = bus.o_tx_data;
            hold_addr = bus.o_addr_log;
        end
    end

    initial begin
        #500us;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int r0;
        int d0;

        i_rst           = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd       = 2'd0;
        bus.i_mem_full  = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        i_rst = 1'b0;
        step();

        // DUMP before any capture is ignored.
        r0 = read_cnt;
        cmd(C_DUMP);
        n = 0;
        repeat (8) begin
            if (bus.o_busy) n++;
            step();
        end
        chk("dump_ignored_read", read_cnt - r0, 0);
        chk("dump_ignored_busy_cycles", n, 0);

        // CAPTURE with memory never full: watchdog expiry.
        r0 = run_cnt;
        cmd(C_CAPTURE);
        chk("capture_run_pulse", bus.o_run_log, 1);
        chk("capture_busy", bus.o_busy, 1);
        n = 0;
        while (!bus.o_timeout && n < 40) begin
            step();
            n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_busy", bus.o_busy, 0);
        chk("timeout_run_pulses", run_cnt - r0, 1);

        // Capture with memory full, then straight dump.
        bus.i_mem_full = 1'b1;
        cmd(C_CAPTURE);
        repeat (5) step();
        chk("timeout_cleared", bus.o_timeout, 0);
        chk("ready_busy", bus.o_busy, 1);
        for (int a = 0; a < 8; a++) push_word(a, 4);
        run_dump("dump", 200);

        // Same dump under random backpressure.
        for (int a = 0; a < 8; a++) push_word(a, 4);
        bp_en = 1'b1;
        run_dump("bp", 3000);
        bp_en = 1'b0;
        step();

        // ABORT while byte 2 of address 5 is on the stream.
        for (int a = 0; a < 5; a++) push_word(a, 4);
        push_word(5, 3);
        d0 = done_cnt;
        cmd(C_DUMP);
        n = 0;
        while (!(bus.o_tx_valid && bus.o_addr_log == 3'd5 && bus.o_tx_data == 8'hFF) && n < 300) begin
            step();
            n++;
        end
        chk("abort_reached_addr5_byte2", (n < 300), 1);
        cmd(C_ABORT);
        chk("abort_valid_drop", bus.o_tx_valid, 0);
        repeat (4) step();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_queue_empty", exp_q.size(), 0);
        chk("abort_idle", bus.o_busy, 0);

        // DUMP after ABORT restarts from address 0.
        for (int a = 0; a < 8; a++) push_word(a, 4);
        run_dump("redump", 200);

        // Asynchronous reset in the middle of SEND.
        for (int a = 0; a < 8; a++) push_word(a, 4);
        cmd(C_DUMP);
        n = 0;
        while (!(bus.o_tx_valid && bus.o_addr_log == 3'd2) && n < 100) begin
            step();
            n++;
        end
        chk("rst_reached_send", bus.o_tx_valid, 1);
        #3;
        i_rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        exp_q.delete();
        repeat (2) step();
        i_rst = 1'b0;
        step();

        // Normal operation after reset.
        r0 = run_cnt;
        cmd(C_CAPTURE);
        chk("post_rst_run_pulse", bus.o_run_log, 1);
        chk("post_rst_busy", bus.o_busy, 1);
        repeat (5) step();
        chk("post_rst_run_count", run_cnt - r0, 1);
        for (int a = 0; a < 8; a++) push_word(a, 4);
        run_dump("post_rst_dump", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
